cnn_img_loader: RTL



---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_img_loader_if.sv | 24 ++
 rtl/cnn_img_buf.sv | 28 ++
 rtl/cnn_img_loader.sv | 111 +++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and pixel clamp helper for the CNN image loader.
package cnn_pkg;

    localparam int unsigned PIX_W   = 32;
    localparam int unsigned IMG_PIX = 64;

    typedef enum logic [1:0] {StFill, StRun, StOut} state_e;

    // Saturate a signed pixel into the 8-bit unsigned range [0,255].
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [PIX_W-1:0] pix);
        if (pix < 0) begin
            return '0;
        end else if (pix > 255) begin
            return PIX_W'(255);
        end
        return pix;
    endfunction

endpackage

// File: rtl/cnn_img_loader_if.sv
// Pixel-in and result-out valid/ready streams of the CNN image loader.
interface cnn_img_loader_if #(
    parameter int unsigned PIX_W = cnn_pkg::PIX_W
) ();

    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_last;
    logic             res_valid;
    logic             res_ready;
    logic [PIX_W-1:0] res_data;

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, res_data
    );

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, res_data
    );

endinterface

// File: rtl/cnn_img_buf.sv
// Image register file: single write port, whole contents presented as one flat vector.
module cnn_img_buf
    import cnn_pkg::*;
#(
    parameter int unsigned Depth = IMG_PIX,
    parameter int unsigned Width = PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] addr,
    input  logic [Width-1:0]         data,
    output logic [Depth*Width-1:0]   flat
);

    logic [Depth*Width-1:0] flat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flat_q <= '0;
        end else if (we) begin
            flat_q[addr*Width +: Width] <= data;
        end
    end

    assign flat = flat_q;

endmodule

// File: rtl/cnn_img_loader.sv
// Streams an 8x8 frame into a parallel buffer, runs the CNN core and returns its result.
// Define CNN_LOADER_CLAMP_EN to saturate stored pixels to [0,255].
module cnn_img_loader #(
    parameter int unsigned PIX_W   = cnn_pkg::PIX_W,
    parameter int unsigned IMG_PIX = cnn_pkg::IMG_PIX
) (
    input  logic                     clk,
    input  logic                     rst,
    cnn_img_loader_if.slave          bus,
    output logic [IMG_PIX*PIX_W-1:0] img_flat,
    output logic                     cnn_enable,
    input  logic                     cnn_done,
    input  logic [PIX_W-1:0]         cnn_value,
    output logic                     cnn_clear,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);
    import cnn_pkg::*;

    localparam int unsigned CntW = $clog2(IMG_PIX);

    state_e           state;
    logic [CntW-1:0]  cnt;
    logic             s_ready_q;
    logic             res_valid_q;
    logic [PIX_W-1:0] res_data_q;
    logic [PIX_W-1:0] wr_data;
    logic             accept;
    logic             last_pix;

    // s_ready_q is only ever high in StFill, so it alone qualifies an accept.
    assign accept   = s_ready_q & bus.s_valid;
    assign last_pix = (cnt == CntW'(IMG_PIX - 1));

`ifdef CNN_LOADER_CLAMP_EN
    assign wr_data = clamp_pix(bus.s_data);
`else
    assign wr_data = bus.s_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StFill;
            cnt         <= '0;
            s_ready_q   <= 1'b0;
            cnn_enable  <= 1'b0;
            cnn_clear   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            cnn_clear <= 1'b0;
            unique case (state)
                StFill: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (last_pix) begin
                            state      <= StRun;
                            cnt        <= '0;
                            s_ready_q  <= 1'b0;
                            cnn_enable <= 1'b1;
                            if (!bus.s_last) frame_err <= 1'b1;
                        end else if (bus.s_last) begin
                            // Short frame: drop it, keep stale buffer contents.
                            cnt       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            cnt <= cnt + CntW'(1);
                        end
                    end
                end
                StRun: begin
                    if (cnn_done) begin
                        res_data_q  <= cnn_value;
                        cnn_enable  <= 1'b0;
                        res_valid_q <= 1'b1;
                        state       <= StOut;
                    end
                end
                StOut: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cnn_clear   <= 1'b1;
                        frame_cnt   <= frame_cnt + 16'd1;
                        s_ready_q   <= 1'b1;
                        state       <= StFill;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    cnn_img_buf #(
        .Depth (IMG_PIX),
        .Width (PIX_W)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (accept),
        .addr (cnt),
        .data (wr_data),
        .flat (img_flat)
    );

endmodule
